// File: rtl/canny_pkg.sv
// Shared definitions for the edge-detection pipeline.
//   PIX_W   : grayscale pixel width
//   WIN_W   : width of a packed 3x3 window word
//   pixel_t : one grayscale pixel
//   win_idx : byte index of window element (row r, column c); the Sobel stage
//             uses the same layout
package canny_pkg;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned WIN_W = 72;

  typedef logic [PIX_W-1:0] pixel_t;

  function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
    return 3 * r + c;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// Single-port line store, DEPTH x 8, read-first.
//   clk   : write clock
//   we    : write enable
//   addr  : shared read/write address
//   wdata : pixel written at the rising edge when we = 1
//   rdata : combinational read of the contents before any write this cycle
// No reset; contents are undefined until written.
module line_buffer
  import canny_pkg::*;
#(
  parameter int unsigned DEPTH  = 640,
  parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  pixel_t            wdata,
  output pixel_t            rdata
);

  pixel_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/window_3x3.sv
// Streaming 3x3 neighbourhood generator.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : in_pixel valid this cycle (no backpressure)
//   in_pixel   : grayscale pixel, raster order
//   in_sof     : with in_valid, this pixel is (0,0) of a new frame
//   out_valid  : pixels_g and flags valid
//   pixels_g   : window, byte 3r+c = row r (0 top), column c (0 left)
//   out_sof    : window centred on (1,1)
//   out_eol    : window centred on column IMG_WIDTH-2
//   out_eof    : window centred on (IMG_WIDTH-2, IMG_HEIGHT-2)
module window_3x3
  import canny_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             in_sof,
  output logic             out_valid,
  output logic [WIN_W-1:0] pixels_g,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_eof
);

  localparam int unsigned XW = $clog2(IMG_WIDTH);
  localparam int unsigned YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
  localparam logic [XW-1:0] X_MIN  = XW'(2);
  localparam logic [YW-1:0] Y_MIN  = YW'(2);

  logic [XW-1:0]    x_q, x_d, cur_x;
  logic [YW-1:0]    y_q, y_d, cur_y;
  logic [WIN_W-1:0] win_q, win_d;
  logic [WIN_W-1:0] pix_q, pix_d;
  logic             valid_q, valid_d;
  logic             sof_q, sof_d;
  logic             eol_q, eol_d;
  logic             eof_q, eof_d;
  pixel_t           l1_rd, l2_rd;

  // line1 holds row y-1, line2 holds row y-2; line2 is refilled from the
  // value line1 held at the same column before this pixel overwrote it.
  line_buffer #(.DEPTH(IMG_WIDTH), .ADDR_W(XW)) u_line1 (
    .clk   (clk),
    .we    (in_valid),
    .addr  (cur_x),
    .wdata (in_pixel),
    .rdata (l1_rd)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .ADDR_W(XW)) u_line2 (
    .clk   (clk),
    .we    (in_valid),
    .addr  (cur_x),
    .wdata (l1_rd),
    .rdata (l2_rd)
  );

  always_comb begin
    cur_x   = in_sof ? '0 : x_q;
    cur_y   = in_sof ? '0 : y_q;
    x_d     = x_q;
    y_d     = y_q;
    win_d   = win_q;
    pix_d   = pix_q;
    valid_d = 1'b0;
    sof_d   = 1'b0;
    eol_d   = 1'b0;
    eof_d   = 1'b0;

    if (in_valid) begin
      y_d = cur_y;
      if (cur_x == X_LAST) begin
        x_d = '0;
        y_d = (cur_y == Y_LAST) ? '0 : cur_y + YW'(1);
      end else begin
        x_d = cur_x + XW'(1);
      end

      for (int unsigned r = 0; r < 3; r++) begin
        for (int unsigned c = 0; c < 2; c++) begin
          win_d[8*win_idx(r, c) +: 8] = win_q[8*win_idx(r, c + 1) +: 8];
        end
      end
      win_d[8*win_idx(0, 2) +: 8] = l2_rd;
      win_d[8*win_idx(1, 2) +: 8] = l1_rd;
      win_d[8*win_idx(2, 2) +: 8] = in_pixel;

      // pixels_g is a separate copy so it holds the last emitted window while
      // border pixels keep shifting the working window.
      if (cur_x >= X_MIN && cur_y >= Y_MIN) begin
        valid_d = 1'b1;
        pix_d   = win_d;
        sof_d   = (cur_x == X_MIN) && (cur_y == Y_MIN);
        eol_d   = (cur_x == X_LAST);
        eof_d   = (cur_x == X_LAST) && (cur_y == Y_LAST);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      win_q   <= '0;
      pix_q   <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      win_q   <= win_d;
      pix_q   <= pix_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
    end
  end

  assign out_valid = valid_q;
  assign pixels_g  = pix_q;
  assign out_sof   = sof_q;
  assign out_eol   = eol_q;
  assign out_eof   = eof_q;

endmodule

// File: tb/tb_window_3x3.sv
module tb_window_3x3;

  localparam int W = 5;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_pixel = '0;
  logic        in_sof = 1'b0;
  logic        out_valid;
  logic [71:0] pixels_g;
  logic        out_sof, out_eol, out_eof;

  window_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_pixel  (in_pixel),
    .in_sof    (in_sof),
    .out_valid (out_valid),
    .pixels_g  (pixels_g),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .out_eof   (out_eof)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model: the current frame as a picture plus the input coordinate
  logic [7:0]  img [H][W];
  int          mx = 0, my = 0;
  logic [74:0] exp_q [$];
  logic [74:0] win_log [$];
  bit          alt_mode = 0;

  task automatic chk(input string name, input logic [74:0] got, input logic [74:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  function automatic logic [71:0] pack9(input int b0, b1, b2, b3, b4, b5, b6, b7, b8);
    int v [9];
    logic [71:0] w;
    v = '{b0, b1, b2, b3, b4, b5, b6, b7, b8};
    for (int k = 0; k < 9; k++) w[8*k +: 8] = 8'(v[k]);
    return w;
  endfunction

  logic [71:0] P1_FIRST, P1_LAST;

  task automatic model_accept(input logic [7:0] p, input logic s);
    logic [71:0] w;
    if (s) begin mx = 0; my = 0; end
    img[my][mx] = p;
    if (mx >= 2 && my >= 2) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w[8*(3*r+c) +: 8] = img[my-2+r][mx-2+c];
      exp_q.push_back({w, (mx == 2 && my == 2), (mx == W-1), (mx == W-1 && my == H-1)});
    end
    mx++;
    if (mx == W) begin
      mx = 0;
      my = (my == H-1) ? 0 : my + 1;
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] p, input logic s);
    @(posedge clk); #1;
    in_valid = v; in_pixel = p; in_sof = s;
    if (v) model_accept(p, s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_frame(input bit sof, input bit alt);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        drive(1'b1, 8'(16*y + x), sof && x == 0 && y == 0);
        if (alt) drive(1'b0, 8'h00, 1'b0);
      end
  endtask

  // monitor: pops the scoreboard whenever the DUT presents a window
  initial begin : monitor
    logic [74:0] got, e;
    bit prev_valid;
    prev_valid = 0;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        got = {pixels_g, out_sof, out_eol, out_eof};
        win_log.push_back(got);
        if (exp_q.size() == 0) begin
          chk("unexpected_window", got, '0);
        end else begin
          e = exp_q.pop_front();
          chk("window", got, e);
        end
        if (alt_mode) chk("no_back_to_back", 75'(prev_valid), 75'(0));
      end else begin
        chk("flags_idle", {72'h0, out_sof, out_eol, out_eof}, '0);
      end
      prev_valid = out_valid;
    end
  end

  initial begin : main
    int base;
    P1_FIRST = pack9(0, 1, 2, 16, 17, 18, 32, 33, 34);
    P1_LAST  = pack9(18, 19, 20, 34, 35, 36, 50, 51, 52);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {pixels_g, out_valid, out_sof, out_eol}, '0);
    chk("reset_eof", 75'(out_eof), '0);
    rst_n = 1'b1;
    idle(2);

    // 1 + 6: single contiguous frame
    base = win_log.size();
    send_frame(1, 0); idle(3);
    chk("s1_count", 75'(win_log.size() - base), 75'(6));
    chk("s1_first", win_log[base], {P1_FIRST, 3'b100});
    chk("s1_last", win_log[base+5], {P1_LAST, 3'b011});
    chk("s6_eol_3rd", 75'(win_log[base+2][1]), 75'(1));
    chk("s6_eol_2nd", 75'(win_log[base+1][1]), 75'(0));

    // 2: alternating valid
    alt_mode = 1;
    base = win_log.size();
    send_frame(1, 1); idle(3);
    alt_mode = 0;
    chk("s2_count", 75'(win_log.size() - base), 75'(6));
    chk("s2_first", win_log[base][74:3], 75'(P1_FIRST));
    chk("s2_last", win_log[base+5][74:3], 75'(P1_LAST));

    // 3: back-to-back frames, auto wrap
    base = win_log.size();
    send_frame(1, 0); send_frame(0, 0); idle(3);
    chk("s3_count", 75'(win_log.size() - base), 75'(12));
    chk("s3_sof_1st", 75'(win_log[base][2]), 75'(1));
    chk("s3_sof_7th", 75'(win_log[base+6][2]), 75'(1));
    chk("s3_7th_win", win_log[base+6][74:3], 75'(P1_FIRST));

    // 4: restart at (3,2)
    base = win_log.size();
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < W; x++)
        if (!(y == 2 && x > 2)) drive(1'b1, 8'(16*y + x), x == 0 && y == 0);
    send_frame(1, 0); idle(3);
    chk("s4_count", 75'(win_log.size() - base), 75'(7));
    chk("s4_restart_first", win_log[base+1], {P1_FIRST, 3'b100});
    chk("s4_restart_last", win_log[base+6], {P1_LAST, 3'b011});

    // 5: async reset mid-line
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (!(y == 3 && x > 2)) drive(1'b1, 8'(16*y + x), x == 0 && y == 0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0;
    #6;
    rst_n = 1'b0;
    #1;
    chk("s5_reset_outputs", {pixels_g, out_valid, out_sof, out_eol}, '0);
    chk("s5_reset_eof", 75'(out_eof), '0);
    chk("s5_queue_drained", 75'(exp_q.size()), '0);
    mx = 0; my = 0;
    #5;
    rst_n = 1'b1;
    idle(2);
    base = win_log.size();
    send_frame(0, 0); idle(3);
    chk("s5_count", 75'(win_log.size() - base), 75'(6));
    chk("s5_first", win_log[base], {P1_FIRST, 3'b100});
    chk("s5_last", win_log[base+5], {P1_LAST, 3'b011});

    // randomized pixels, gaps and stray in_sof against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) drive(1'b0, 8'($urandom), 1'($urandom));
      else drive(1'b1, 8'($urandom), $urandom_range(0, 49) == 0);
    end
    idle(4);
    chk("final_queue_empty", 75'(exp_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
